// File: rtl/timer_job_sequencer_if.sv
// Register bus between the job sequencer (master) and the 8-bit timer (slave).
interface timer_job_sequencer_if;
  logic       bus_sel;
  logic       bus_wr;
  logic [7:0] bus_addr;
  logic [7:0] bus_wdata;
  logic [7:0] bus_rdata;
  logic       bus_ready;

  modport master (
    output bus_sel, bus_wr, bus_addr, bus_wdata,
    input  bus_rdata, bus_ready
  );

  modport slave (
    input  bus_sel, bus_wr, bus_addr, bus_wdata,
    output bus_rdata, bus_ready
  );
endinterface

// File: rtl/timer_job_sequencer.sv
// Sequences one timer job over the register bus: load, start, wait for irq, read/clear TSR, stop.
// Optional WAIT_IRQ watchdog: define TIMER_JOB_SEQUENCER_TIMEOUT_EN.
module timer_job_sequencer #(
  parameter logic [7:0]  TDR_ADDR    = 8'h00,
  parameter logic [7:0]  TCR_ADDR    = 8'h01,
  parameter logic [7:0]  TSR_ADDR    = 8'h02,
  parameter int unsigned TIMEOUT_CYC = 4096
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          job_valid,
  output logic                          job_ready,
  input  logic [7:0]                    job_init,
  input  logic                          job_dir,
  input  logic [1:0]                    job_cks,
  input  logic                          abort,
  output logic                          busy,
  output logic                          done_valid,
  output logic [2:0]                    done_status,
  timer_job_sequencer_if.master         bus,
  input  logic                          timer_irq
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_WR_TDR,
    S_WR_LOAD,
    S_WR_START,
    S_WAIT_IRQ,
    S_RD_TSR,
    S_CLR_TSR,
    S_STOP,
    S_DONE
  } state_e;

  state_e     state_q, state_d;
  logic       gap_q, gap_d;
  logic       pend_q, pend_d;
  logic [7:0] init_q, init_d;
  logic       dir_q, dir_d;
  logic [1:0] cks_q, cks_d;
  logic [1:0] sts_q, sts_d;
  logic       to_q, to_d;
  logic       timeout_hit;

`ifdef TIMER_JOB_SEQUENCER_TIMEOUT_EN
  logic [15:0] wcnt_q, wcnt_d;

  assign wcnt_d      = (state_q == S_WAIT_IRQ) ? wcnt_q + 16'd1 : '0;
  assign timeout_hit = (state_q == S_WAIT_IRQ) && (wcnt_q == 16'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wcnt_q <= '0;
    else        wcnt_q <= wcnt_d;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      gap_q   <= 1'b0;
      pend_q  <= 1'b0;
      init_q  <= '0;
      dir_q   <= 1'b0;
      cks_q   <= '0;
      sts_q   <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      pend_q  <= pend_d;
      init_q  <= init_d;
      dir_q   <= dir_d;
      cks_q   <= cks_d;
      sts_q   <= sts_d;
      to_q    <= to_d;
    end
  end

  state_e     nxt;
  logic       is_xfer;
  logic       sel_c, wr_c;
  logic [7:0] addr_c, wdata_c;

  // Every bus state runs two phases: request (gap_q=0) held until bus_ready,
  // then one idle cycle (gap_q=1) in which the next state is chosen.
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    pend_d  = pend_q;
    init_d  = init_q;
    dir_d   = dir_q;
    cks_d   = cks_q;
    sts_d   = sts_q;
    to_d    = to_q;
    nxt     = S_IDLE;
    is_xfer = 1'b0;
    sel_c   = 1'b0;
    wr_c    = 1'b0;
    addr_c  = '0;
    wdata_c = '0;

    case (state_q)
      S_IDLE: begin
        if (job_valid) begin
          init_d  = job_init;
          dir_d   = job_dir;
          cks_d   = job_cks;
          sts_d   = '0;
          to_d    = 1'b0;
          pend_d  = 1'b0;
          gap_d   = 1'b0;
          state_d = S_WR_TDR;
        end
      end
      S_WR_TDR: begin
        is_xfer = 1'b1;
        wr_c    = 1'b1;
        addr_c  = TDR_ADDR;
        wdata_c = init_q;
        nxt     = S_WR_LOAD;
      end
      S_WR_LOAD: begin
        is_xfer = 1'b1;
        wr_c    = 1'b1;
        addr_c  = TCR_ADDR;
        wdata_c = {1'b1, 1'b0, dir_q, 1'b0, 2'b00, cks_q};
        nxt     = S_WR_START;
      end
      S_WR_START: begin
        is_xfer = 1'b1;
        wr_c    = 1'b1;
        addr_c  = TCR_ADDR;
        wdata_c = {1'b0, 1'b0, dir_q, 1'b1, 2'b00, cks_q};
        nxt     = S_WAIT_IRQ;
      end
      S_WAIT_IRQ: begin
        if (abort) begin
          state_d = S_STOP;
        end else if (timer_irq) begin
          state_d = S_RD_TSR;
        end else if (timeout_hit) begin
          to_d    = 1'b1;
          state_d = S_RD_TSR;
        end
      end
      S_RD_TSR: begin
        is_xfer = 1'b1;
        addr_c  = TSR_ADDR;
        nxt     = S_CLR_TSR;
      end
      S_CLR_TSR: begin
        is_xfer = 1'b1;
        wr_c    = 1'b1;
        addr_c  = TSR_ADDR;
        wdata_c = {6'b000000, sts_q};
        // A spurious irq (nothing captured, no watchdog) resumes waiting with the timer still running.
        nxt     = (sts_q == 2'b00 && !to_q) ? S_WAIT_IRQ : S_STOP;
      end
      S_STOP: begin
        is_xfer = 1'b1;
        wr_c    = 1'b1;
        addr_c  = TCR_ADDR;
        wdata_c = 8'h00;
        nxt     = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (is_xfer) begin
      if (!gap_q) begin
        sel_c = 1'b1;
        if (abort) pend_d = 1'b1;
        if (bus.bus_ready) begin
          gap_d = 1'b1;
          if (state_q == S_RD_TSR) sts_d = bus.bus_rdata[1:0];
        end
      end else begin
        wr_c    = 1'b0;
        addr_c  = '0;
        wdata_c = '0;
        gap_d   = 1'b0;
        pend_d  = 1'b0;
        state_d = ((pend_q || abort) && state_q != S_STOP) ? S_STOP : nxt;
      end
    end
  end

  assign bus.bus_sel   = sel_c;
  assign bus.bus_wr    = wr_c;
  assign bus.bus_addr  = addr_c;
  assign bus.bus_wdata = wdata_c;

  assign job_ready   = (state_q == S_IDLE);
  assign busy        = (state_q != S_IDLE);
  assign done_valid  = (state_q == S_DONE);
  assign done_status = (state_q == S_DONE) ? {to_q, sts_q} : 3'b000;

endmodule

// File: tb/tb_timer_job_sequencer.sv
// Self-checking bench for timer_job_sequencer: bus slave + timer irq model and a transaction-level reference.
module tb_timer_job_sequencer;

  localparam int         TO_CYC = 64;
  localparam logic [7:0] TDR    = 8'h00;
  localparam logic [7:0] TCR    = 8'h01;
  localparam logic [7:0] TSR    = 8'h02;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       job_valid = 1'b0;
  logic       job_ready;
  logic [7:0] job_init = '0;
  logic       job_dir = 1'b0;
  logic [1:0] job_cks = '0;
  logic       abort = 1'b0;
  logic       busy;
  logic       done_valid;
  logic [2:0] done_status;
  logic       timer_irq = 1'b0;

  timer_job_sequencer_if bif ();

  timer_job_sequencer #(.TIMEOUT_CYC(TO_CYC)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .job_valid  (job_valid),
    .job_ready  (job_ready),
    .job_init   (job_init),
    .job_dir    (job_dir),
    .job_cks    (job_cks),
    .abort      (abort),
    .busy       (busy),
    .done_valid (done_valid),
    .done_status(done_status),
    .bus        (bif),
    .timer_irq  (timer_irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] init;
    logic       dir;
    logic [1:0] cks;
    int         wait_n;
    int         irq_dly;     // 0: timer never interrupts
    logic [1:0] tsr;         // status the timer reports on the real interrupt
    int         spur;        // spurious interrupts (TSR reads 00) before the real one
    int         abort_at;    // 0 none, 1 during first transfer, 2 in WAIT_IRQ
    logic [2:0] exp_status;
  } vec_t;

  typedef struct {
    logic       wr;
    logic [7:0] addr;
    logic [7:0] data;
  } xfer_t;

  xfer_t act_q[$];
  xfer_t exp_q[$];
  int    start_cyc_q[$];
  vec_t  vecs[$];

  int errors = 0;
  int checks = 0;

  vec_t       cur;
  int         cyc = 0;
  int         wcnt = 0;
  int         k = 0;
  bit         armed = 0;
  bit         in_xfer = 0;
  bit         idle_abort_req = 0;
  bit         abort_done = 0;
  int         spur_left = 0;
  int         last_done = -10;
  int         sw_ready_cyc = 0;
  int         tsr_start_cyc = -1;
  logic       s_wr;
  logic [7:0] s_addr, s_wdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Bus slave, timer interrupt source and abort generator, all driven on the falling edge.
  always @(negedge clk) begin
    logic [7:0] rd;
    cyc++;
    abort = 1'b0;
    if (idle_abort_req) begin
      abort = 1'b1;
      idle_abort_req = 0;
    end
    if (armed) k++;
    if (armed && cur.irq_dly != 0 && k == cur.irq_dly) timer_irq = 1'b1;
    if (armed && cur.abort_at == 2 && !abort_done && k == 5) begin
      abort = 1'b1;
      abort_done = 1;
    end
    if (!bif.bus_sel) begin
      in_xfer = 0;
      wcnt = 0;
      bif.bus_ready = 1'($urandom_range(0, 1));
      bif.bus_rdata = 8'($urandom);
    end else begin
      if (!in_xfer) begin
        in_xfer = 1;
        s_wr = bif.bus_wr;
        s_addr = bif.bus_addr;
        s_wdata = bif.bus_wdata;
        chk("idle_gap", 32'(cyc - last_done >= 2), 1);
        start_cyc_q.push_back(cyc);
        if (cur.abort_at == 1 && !abort_done) begin
          abort = 1'b1;
          abort_done = 1;
        end
        if (!s_wr && s_addr == TSR && tsr_start_cyc < 0) tsr_start_cyc = cyc;
      end else begin
        chk("bus_hold", {bif.bus_wr, bif.bus_addr, bif.bus_wdata}, {s_wr, s_addr, s_wdata});
      end
      if (wcnt >= cur.wait_n) begin
        bif.bus_ready = 1'b1;
        last_done = cyc;
        if (!s_wr) begin
          rd = 8'($urandom);
          if (s_addr == TSR) rd[1:0] = (spur_left > 0) ? 2'b00 : cur.tsr;
          bif.bus_rdata = rd;
          act_q.push_back('{1'b0, s_addr, 8'h00});
        end else begin
          act_q.push_back('{1'b1, s_addr, s_wdata});
          if (s_addr == TCR && s_wdata[4]) begin
            armed = 1;
            k = 0;
            sw_ready_cyc = cyc;
          end else if (s_addr == TSR) begin
            timer_irq = 1'b0;
            if (spur_left > 0) begin
              spur_left--;
              armed = 1;
              k = 0;
            end else begin
              armed = 0;
            end
          end else if (s_addr == TCR && s_wdata == 8'h00) begin
            armed = 0;
            timer_irq = 1'b0;
          end
        end
      end else begin
        bif.bus_ready = 1'b0;
        wcnt++;
      end
    end
  end

  // Reference: the register transactions a job must produce, from the job alone.
  function automatic void build_exp(input vec_t v);
    exp_q.delete();
    exp_q.push_back('{1'b1, TDR, v.init});
    if (v.abort_at == 1) begin
      exp_q.push_back('{1'b1, TCR, 8'h00});
      return;
    end
    exp_q.push_back('{1'b1, TCR, 8'(128 + 32 * int'(v.dir) + int'(v.cks))});
    exp_q.push_back('{1'b1, TCR, 8'(16 + 32 * int'(v.dir) + int'(v.cks))});
    if (v.abort_at == 2) begin
      exp_q.push_back('{1'b1, TCR, 8'h00});
      return;
    end
    for (int i = 0; i < v.spur; i++) begin
      exp_q.push_back('{1'b0, TSR, 8'h00});
      exp_q.push_back('{1'b1, TSR, 8'h00});
    end
    exp_q.push_back('{1'b0, TSR, 8'h00});
    exp_q.push_back('{1'b1, TSR, 8'(v.tsr)});
    exp_q.push_back('{1'b1, TCR, 8'h00});
  endfunction

  function automatic logic [2:0] model_status(input vec_t v);
    if (v.abort_at != 0) return 3'b000;
    if (v.irq_dly == 0)  return 3'b100;
    return {1'b0, v.tsr};
  endfunction

  task automatic setup_env(input vec_t v);
    cur = v;
    spur_left = v.spur;
    abort_done = 0;
    tsr_start_cyc = -1;
    armed = 0;
    timer_irq = 1'b0;
    act_q.delete();
    start_cyc_q.delete();
  endtask

  task automatic run_job(input vec_t v, input string tag);
    int t;
    setup_env(v);
    build_exp(v);
    idle_abort_req = 1;
    repeat (3) @(negedge clk);
    chk({tag, ":idle_abort_ready"}, job_ready, 1);
    chk({tag, ":idle_abort_nobus"}, act_q.size(), 0);
    job_init  = v.init;
    job_dir   = v.dir;
    job_cks   = v.cks;
    job_valid = 1'b1;
    @(negedge clk);
    chk({tag, ":ready_drop"}, job_ready, 0);
    chk({tag, ":busy_rise"}, busy, 1);
    t = 0;
    while (!done_valid && t < 20000) begin
      @(negedge clk);
      t++;
    end
    if (!done_valid) begin
      chk({tag, ":done_timeout"}, 0, 1);
    end else begin
      chk({tag, ":status"}, done_status, v.exp_status);
      chk({tag, ":ready_in_done"}, job_ready, 0);
    end
    @(negedge clk);
    chk({tag, ":done_single"}, done_valid, 0);
    chk({tag, ":ready_after"}, job_ready, 1);
    chk({tag, ":busy_after"}, busy, 0);
    job_valid = 1'b0;
    chk({tag, ":nxfer"}, act_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < act_q.size(); i++)
      chk($sformatf("%s:xfer%0d", tag, i), {act_q[i].wr, act_q[i].addr, act_q[i].data},
          {exp_q[i].wr, exp_q[i].addr, exp_q[i].data});
    if (v.abort_at == 0 && start_cyc_q.size() >= 3) begin
      chk({tag, ":lat01"}, start_cyc_q[1] - start_cyc_q[0], v.wait_n + 2);
      chk({tag, ":lat12"}, start_cyc_q[2] - start_cyc_q[1], v.wait_n + 2);
      chk({tag, ":wait_irq_len"}, tsr_start_cyc - sw_ready_cyc,
          (v.irq_dly != 0) ? v.irq_dly + 1 : TO_CYC + 2);
    end
  endtask

  initial begin
    vec_t v;
    bit   found, seen_done;
    bif.bus_ready = 1'b0;
    bif.bus_rdata = '0;

    //            init   dir   cks  wait irq tsr  spur abort status
    vecs.push_back('{8'hF0, 1'b0, 2'd0, 0, 16, 2'd1, 0, 0, 3'b001});
    vecs.push_back('{8'h05, 1'b1, 2'd3, 0, 20, 2'd2, 0, 0, 3'b010});
    vecs.push_back('{8'h3C, 1'b0, 2'd2, 3, 10, 2'd1, 0, 0, 3'b001});
    vecs.push_back('{8'h77, 1'b1, 2'd1, 0,  0, 2'd0, 0, 2, 3'b000});
    vecs.push_back('{8'h12, 1'b0, 2'd1, 1,  8, 2'd3, 1, 0, 3'b011});
    vecs.push_back('{8'h99, 1'b0, 2'd0, 3,  0, 2'd0, 0, 1, 3'b000});
`ifdef TIMER_JOB_SEQUENCER_TIMEOUT_EN
    vecs.push_back('{8'hAA, 1'b1, 2'd2, 0,  0, 2'd0, 0, 0, 3'b100});
`endif

    cur = vecs[0];
    repeat (3) @(negedge clk);
    chk("rst:ready", job_ready, 1);
    chk("rst:busy", busy, 0);
    chk("rst:sel", bif.bus_sel, 0);
    chk("rst:done", done_valid, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst:ready", job_ready, 1);
    chk("post_rst:busy", busy, 0);
    chk("post_rst:sel", bif.bus_sel, 0);
    chk("post_rst:status", done_status, 0);

    for (int i = 0; i < vecs.size(); i++) run_job(vecs[i], $sformatf("vec%0d", i));

    for (int i = 0; i < 16; i++) begin
      v.init     = 8'($urandom);
      v.dir      = 1'($urandom);
      v.cks      = 2'($urandom);
      v.wait_n   = $urandom_range(0, 3);
      v.irq_dly  = $urandom_range(3, 40);
      v.tsr      = 2'($urandom_range(1, 3));
      v.spur     = $urandom_range(0, 1);
      v.abort_at = ($urandom_range(0, 4) == 0) ? 2 : 0;
      if (v.abort_at == 2) v.irq_dly = 0;
      v.exp_status = model_status(v);
      run_job(v, $sformatf("rnd%0d", i));
    end

    // Asynchronous reset while the load write is on the bus.
    v = '{8'h5A, 1'b0, 2'd1, 3, 10, 2'd1, 0, 0, 3'b001};
    setup_env(v);
    job_init  = v.init;
    job_dir   = v.dir;
    job_cks   = v.cks;
    job_valid = 1'b1;
    found = 0;
    for (int t = 0; t < 50 && !found; t++) begin
      @(negedge clk);
      if (bif.bus_sel && bif.bus_addr == TCR && bif.bus_wdata[7]) found = 1;
    end
    chk("midrst:found_load", found, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst:sel_drop", bif.bus_sel, 0);
    chk("midrst:ready", job_ready, 1);
    chk("midrst:busy", busy, 0);
    chk("midrst:done", done_valid, 0);
    job_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    seen_done = 0;
    repeat (10) begin
      @(negedge clk);
      if (done_valid || bif.bus_sel) seen_done = 1;
    end
    chk("midrst:no_completion", seen_done, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1, "watchdog");
  end

endmodule
